// File: rtl/jtag_pkg.sv
// Shared constants for the JTAG instruction register: default opcodes, the mandatory capture
// pattern and the decode index that the DR mux uses to pick a data register.
package jtag_pkg;

   localparam int unsigned IrWidthMin = 2;
   localparam int unsigned IrWidthMax = 16;

   localparam logic [3:0] OpcExtest = 4'b0000;
   localparam logic [3:0] OpcSample = 4'b0001;
   localparam logic [3:0] OpcIdcode = 4'b0010;
   localparam logic [3:0] OpcBypass = 4'b1111;

   // The two LSBs captured in Capture-IR let a board tester locate IR boundaries.
   localparam logic [1:0] CapturePattern = 2'b01;

   typedef enum logic [1:0] {
      DecExtest = 2'd0,
      DecSample = 2'd1,
      DecIdcode = 2'd2,
      DecBypass = 2'd3
   } instr_idx_e;

   localparam int unsigned NumInstr = 4;

   function automatic logic [NumInstr-1:0] idx_onehot(instr_idx_e idx);
      logic [NumInstr-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/jtag_ir_reg_if.sv
// TAP-side signal bundle for the instruction register: strobes and serial data from the TAP,
// decoded instruction back to the DR mux.
interface jtag_ir_reg_if #(
   parameter int unsigned IR_WIDTH = 4
);
   // A 2-bit IR has no status field; a single unused bit keeps the vector width legal.
   localparam int unsigned StatusW = (IR_WIDTH > 2) ? IR_WIDTH - 2 : 1;

   logic                TDI;
   logic                TDO;
   logic                IR_SELECT;
   logic                CAPTURE;
   logic                SHIFT;
   logic                UPDATE;
   logic                TLR;
   logic [StatusW-1:0]  STATUS;
   logic [IR_WIDTH-1:0] INSTR_REG;
   logic                INSTR_EXTEST;
   logic                INSTR_SAMPLE;
   logic                INSTR_IDCODE;
   logic                INSTR_BYPASS;
   logic                INSTR_UPDATED;

   modport master (
      output TDI, IR_SELECT, CAPTURE, SHIFT, UPDATE, TLR, STATUS,
      input  TDO, INSTR_REG, INSTR_EXTEST, INSTR_SAMPLE, INSTR_IDCODE, INSTR_BYPASS,
             INSTR_UPDATED
   );

   modport slave (
      input  TDI, IR_SELECT, CAPTURE, SHIFT, UPDATE, TLR, STATUS,
      output TDO, INSTR_REG, INSTR_EXTEST, INSTR_SAMPLE, INSTR_IDCODE, INSTR_BYPASS,
             INSTR_UPDATED
   );

endinterface

// File: rtl/jtag_ir_decode.sv
// Combinational opcode match: yields the one-hot decode and replaces unknown opcodes by BYPASS.
module jtag_ir_decode
   import jtag_pkg::*;
#(
   parameter int unsigned         IR_WIDTH   = 4,
   parameter logic [IR_WIDTH-1:0] OPC_EXTEST = IR_WIDTH'(OpcExtest),
   parameter logic [IR_WIDTH-1:0] OPC_SAMPLE = IR_WIDTH'(OpcSample),
   parameter logic [IR_WIDTH-1:0] OPC_IDCODE = IR_WIDTH'(OpcIdcode),
   parameter logic [IR_WIDTH-1:0] OPC_BYPASS = '1
) (
   input  logic [IR_WIDTH-1:0] opcode,
   output logic [IR_WIDTH-1:0] instr,
   output logic [NumInstr-1:0] onehot
);

   always_comb begin
      instr  = opcode;
      onehot = '0;
      if (opcode == OPC_EXTEST) begin
         onehot[DecExtest] = 1'b1;
      end else if (opcode == OPC_SAMPLE) begin
         onehot[DecSample] = 1'b1;
      end else if (opcode == OPC_IDCODE) begin
         onehot[DecIdcode] = 1'b1;
      end else begin
         // BYPASS itself and every unknown opcode land here.
         instr             = OPC_BYPASS;
         onehot[DecBypass] = 1'b1;
      end
   end

endmodule

// File: rtl/jtag_ir_reg.sv
// Parametrised JTAG instruction register: capture/shift stage, parallel hold stage with BYPASS
// substitution, registered one-hot decode and an update pulse.
module jtag_ir_reg
   import jtag_pkg::*;
#(
   parameter int unsigned IR_WIDTH   = 4,
   parameter logic [15:0] OPC_EXTEST = 16'(OpcExtest),
   parameter logic [15:0] OPC_SAMPLE = 16'(OpcSample),
   parameter logic [15:0] OPC_IDCODE = 16'(OpcIdcode),
   // All ones at any width; equals 4'b1111 for the default IR.
   parameter logic [15:0] OPC_BYPASS = '1
) (
   input  logic          TCK,
   input  logic          TRST_N,
   jtag_ir_reg_if.slave  bus
);

   localparam logic [IR_WIDTH-1:0] OpcExtestW = OPC_EXTEST[IR_WIDTH-1:0];
   localparam logic [IR_WIDTH-1:0] OpcSampleW = OPC_SAMPLE[IR_WIDTH-1:0];
   localparam logic [IR_WIDTH-1:0] OpcIdcodeW = OPC_IDCODE[IR_WIDTH-1:0];
   localparam logic [IR_WIDTH-1:0] OpcBypassW = OPC_BYPASS[IR_WIDTH-1:0];
   localparam logic [IR_WIDTH-1:0] ResetShift = IR_WIDTH'(CapturePattern);

   if (IR_WIDTH < IrWidthMin || IR_WIDTH > IrWidthMax) begin : g_err_width
      $error("jtag_ir_reg: IR_WIDTH must lie in 2..16");
   end

   if (OpcExtestW == OpcSampleW || OpcExtestW == OpcIdcodeW || OpcExtestW == OpcBypassW ||
       OpcSampleW == OpcIdcodeW || OpcSampleW == OpcBypassW || OpcIdcodeW == OpcBypassW)
   begin : g_err_dup
      $error("jtag_ir_reg: opcode parameters collide after resizing to IR_WIDTH");
   end

   if (!(&OpcBypassW)) begin : g_err_bypass
      $error("jtag_ir_reg: OPC_BYPASS must be all ones at IR_WIDTH");
   end

   logic [IR_WIDTH-1:0] shift_q, shift_d;
   logic [IR_WIDTH-1:0] instr_q, instr_d;
   logic [NumInstr-1:0] onehot_q, onehot_d;
   logic                updated_q, updated_d;
   logic [IR_WIDTH-1:0] capture_val;
   logic [IR_WIDTH-1:0] dec_instr;
   logic [NumInstr-1:0] dec_onehot;

   if (IR_WIDTH > 2) begin : g_cap_status
      assign capture_val = {bus.STATUS, CapturePattern};
   end else begin : g_cap_plain
      logic unused_status;
      assign unused_status = ^bus.STATUS;
      assign capture_val   = ResetShift;
   end

   // Decodes the pre-edge shift contents so a same-edge SHIFT cannot leak into the update.
   jtag_ir_decode #(
      .IR_WIDTH   (IR_WIDTH),
      .OPC_EXTEST (OpcExtestW),
      .OPC_SAMPLE (OpcSampleW),
      .OPC_IDCODE (OpcIdcodeW),
      .OPC_BYPASS (OpcBypassW)
   ) u_decode (
      .opcode (shift_q),
      .instr  (dec_instr),
      .onehot (dec_onehot)
   );

   always_comb begin
      shift_d   = shift_q;
      instr_d   = instr_q;
      onehot_d  = onehot_q;
      updated_d = 1'b0;
      if (bus.TLR) begin
         shift_d   = ResetShift;
         instr_d   = OpcIdcodeW;
         onehot_d  = idx_onehot(DecIdcode);
         updated_d = 1'b1;
      end else if (bus.IR_SELECT) begin
         if (bus.CAPTURE) begin
            shift_d = capture_val;
         end else if (bus.SHIFT) begin
            shift_d = {bus.TDI, shift_q[IR_WIDTH-1:1]};
         end
         if (bus.UPDATE) begin
            instr_d   = dec_instr;
            onehot_d  = dec_onehot;
            updated_d = 1'b1;
         end
      end
   end

   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) begin
         shift_q   <= ResetShift;
         instr_q   <= OpcIdcodeW;
         onehot_q  <= idx_onehot(DecIdcode);
         updated_q <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         instr_q   <= instr_d;
         onehot_q  <= onehot_d;
         updated_q <= updated_d;
      end
   end

   assign bus.TDO           = shift_q[0];
   assign bus.INSTR_REG     = instr_q;
   assign bus.INSTR_EXTEST  = onehot_q[DecExtest];
   assign bus.INSTR_SAMPLE  = onehot_q[DecSample];
   assign bus.INSTR_IDCODE  = onehot_q[DecIdcode];
   assign bus.INSTR_BYPASS  = onehot_q[DecBypass];
   assign bus.INSTR_UPDATED = updated_q;

endmodule

// File: tb/tb_jtag_ir_reg.sv
// Directed bench for jtag_ir_reg: a reference model pushes per-cycle expectations into a
// scoreboard that is popped and compared after every rising TCK edge.
module tb_jtag_ir_reg;
   import jtag_pkg::*;

   localparam int unsigned W = 4;

   typedef struct {
      string          tag;
      logic [W-1:0]   instr;
      logic [3:0]     dec;
      logic           upd;
      logic           tdo;
   } exp_t;

   logic TCK;
   logic TRST_N;

   jtag_ir_reg_if #(.IR_WIDTH(W)) bus ();

   jtag_ir_reg #(.IR_WIDTH(W)) dut (
      .TCK    (TCK),
      .TRST_N (TRST_N),
      .bus    (bus)
   );

   initial TCK = 1'b0;
   always #5 TCK = ~TCK;

   exp_t         sb[$];
   int           checks;
   int           failures;
   logic [W-1:0] m_shift;
   logic [W-1:0] m_instr;
   logic         m_upd;
   logic [3:0]   tdo_seq;

   function automatic logic [W-1:0] m_subst(logic [W-1:0] v);
      if (v == 4'b0000 || v == 4'b0001 || v == 4'b0010) return v;
      return 4'b1111;
   endfunction

   // Bit order {BYPASS, IDCODE, SAMPLE, EXTEST}.
   function automatic logic [3:0] m_dec(logic [W-1:0] v);
      case (v)
         4'b0000: return 4'b0001;
         4'b0001: return 4'b0010;
         4'b0010: return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push_model(string tag);
      exp_t e;
      e.tag   = tag;
      e.instr = m_instr;
      e.dec   = m_dec(m_instr);
      e.upd   = m_upd;
      e.tdo   = m_shift[0];
      sb.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, "/instr"}, 32'(bus.INSTR_REG), 32'(e.instr));
      chk({e.tag, "/dec"}, 32'({bus.INSTR_BYPASS, bus.INSTR_IDCODE, bus.INSTR_SAMPLE,
                                bus.INSTR_EXTEST}), 32'(e.dec));
      chk({e.tag, "/upd"}, 32'(bus.INSTR_UPDATED), 32'(e.upd));
      chk({e.tag, "/tdo"}, 32'(bus.TDO), 32'(e.tdo));
   endtask

   task automatic cycle(string tag, logic sel, logic cap, logic sh, logic up, logic tdi,
                        logic tlr);
      logic [W-1:0] pre;
      bus.IR_SELECT = sel;
      bus.CAPTURE   = cap;
      bus.SHIFT     = sh;
      bus.UPDATE    = up;
      bus.TDI       = tdi;
      bus.TLR       = tlr;
      pre   = m_shift;
      m_upd = 1'b0;
      if (tlr) begin
         m_shift = 4'b0001;
         m_instr = 4'b0010;
         m_upd   = 1'b1;
      end else if (sel) begin
         if (cap) m_shift = {bus.STATUS, 2'b01};
         else if (sh) m_shift = {tdi, m_shift[W-1:1]};
         if (up) begin
            m_instr = m_subst(pre);
            m_upd   = 1'b1;
         end
      end
      push_model(tag);
      @(posedge TCK);
      #1;
      pop_cmp();
   endtask

   task automatic shift_bits(string tag, logic [3:0] v);
      for (int i = 0; i < 4; i++) cycle(tag, 1'b1, 1'b0, 1'b1, 1'b0, v[i], 1'b0);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      TRST_N        = 1'b0;
      bus.TDI       = 1'b0;
      bus.IR_SELECT = 1'b0;
      bus.CAPTURE   = 1'b0;
      bus.SHIFT     = 1'b0;
      bus.UPDATE    = 1'b0;
      bus.TLR       = 1'b0;
      bus.STATUS    = 2'b10;
      m_shift       = 4'b0001;
      m_instr       = 4'b0010;
      m_upd         = 1'b0;

      #12;
      TRST_N = 1'b1;
      push_model("reset");
      #1;
      pop_cmp();
      chk("reset_instr", 32'(bus.INSTR_REG), 32'h2);
      chk("reset_tdo", 32'(bus.TDO), 32'h1);
      cycle("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Capture {STATUS, 01} and read it out LSB first.
      cycle("capture", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tdo_seq[i] = bus.TDO;
         cycle("shift_cap", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk("tdo_seq", 32'(tdo_seq), 32'h9);

      shift_bits("ld_sample", 4'b0001);
      cycle("upd_sample", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("sample_instr", 32'(bus.INSTR_REG), 32'h1);
      chk("sample_pulse", 32'(bus.INSTR_UPDATED), 32'h1);
      cycle("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pulse_once", 32'(bus.INSTR_UPDATED), 32'h0);

      shift_bits("ld_illegal", 4'b0110);
      cycle("upd_illegal", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("illegal_instr", 32'(bus.INSTR_REG), 32'hf);
      chk("illegal_bypass", 32'(bus.INSTR_BYPASS), 32'h1);
      cycle("upd_b2b", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("b2b_pulse", 32'(bus.INSTR_UPDATED), 32'h1);

      // Same-edge SHIFT+UPDATE latches the old all-zero contents.
      shift_bits("ld_zero", 4'b0000);
      cycle("sh_upd", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("shupd_instr", 32'(bus.INSTR_REG), 32'h0);
      chk("shupd_extest", 32'(bus.INSTR_EXTEST), 32'h1);
      for (int i = 0; i < 3; i++) cycle("sh_adv", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("shift_advanced", 32'(bus.TDO), 32'h1);

      // TLR overrides concurrent strobes.
      cycle("tlr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("tlr_instr", 32'(bus.INSTR_REG), 32'h2);
      chk("tlr_pulse", 32'(bus.INSTR_UPDATED), 32'h1);
      cycle("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      cycle("pre_nosel", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle("nosel", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("nosel_tdo", 32'(bus.TDO), 32'h0);
      chk("nosel_instr", 32'(bus.INSTR_REG), 32'h2);

      // Asynchronous reset in the middle of a shift.
      shift_bits("ld_ext", 4'b0000);
      cycle("upd_ext", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle("mid_sh0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle("mid_sh1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      #2;
      TRST_N  = 1'b0;
      m_shift = 4'b0001;
      m_instr = 4'b0010;
      m_upd   = 1'b0;
      push_model("trst_async");
      #1;
      pop_cmp();
      chk("trst_instr", 32'(bus.INSTR_REG), 32'h2);
      push_model("trst_hold");
      @(posedge TCK);
      #1;
      pop_cmp();
      TRST_N = 1'b1;
      cycle("post_trst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
